// File: rtl/arb4way16_pkg.sv
// arb4way16_pkg: shared widths, arbiter state enum and round-robin pointer helper
package arb4way16_pkg;
  localparam int ARB_N = 4;
  localparam int ARB_W = 16;
  typedef enum logic [1:0] {EMPTY, FULL, LOCKED} state_t;
  function automatic logic [1:0] rr_next(input logic [1:0] p);
    return p + 2'd1;
  endfunction
endpackage

// File: rtl/Mux4Way16.sv
// Mux4Way16: 16-bit 4:1 mux (a,b,c,d in; sel in; out = selected word)
module Mux4Way16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [1:0]  sel,
  output logic [15:0] out
);
  assign out = sel[1] ? (sel[0] ? d : c) : (sel[0] ? b : a);
endmodule

// File: rtl/rr_pick4.sv
// rr_pick4: rotating-priority picker (req,ptr in; grant one-hot, id, any out), first set bit at or after ptr wins
module rr_pick4
  import arb4way16_pkg::*;
(
  input  logic [ARB_N-1:0] req,
  input  logic [1:0]       ptr,
  output logic [ARB_N-1:0] grant,
  output logic [1:0]       id,
  output logic             any
);
  logic [3:0] rot;
  logic [1:0] off;
  always_comb begin
    rot = 4'({req, req} >> ptr);
    off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    id = ptr + off;
    any = |req;
    grant = any ? 4'b0001 << id : 4'b0000;
  end
endmodule

// File: rtl/arbiter4way16.sv
// arbiter4way16: 4-way round-robin arbiter with registered valid/ready output (clk,rst_n,a-d,req_valid,req_lock in; req_ready,out_valid,out_data,out_id out; out_ready in); ARB4WAY16_BURST_EN enables grant locking
module arbiter4way16
  import arb4way16_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ARB_W-1:0] a,
  input  logic [ARB_W-1:0] b,
  input  logic [ARB_W-1:0] c,
  input  logic [ARB_W-1:0] d,
  input  logic [ARB_N-1:0] req_valid,
  input  logic [ARB_N-1:0] req_lock,
  output logic [ARB_N-1:0] req_ready,
  output logic             out_valid,
  output logic [ARB_W-1:0] out_data,
  output logic [1:0]       out_id,
  input  logic             out_ready
);
  state_t state;
  logic [1:0] ptr, win_id;
  logic [ARB_N-1:0] req_eff, grant;
  logic [ARB_W-1:0] mux_out;
  logic any, load_ok, locked;
`ifdef ARB4WAY16_BURST_EN
  assign locked = state == LOCKED && req_valid[out_id];
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign locked = 1'b0;
`endif
  assign out_valid = state != EMPTY;
  assign load_ok = !out_valid || out_ready;
  assign req_eff = locked ? 4'b0001 << out_id : req_valid;
  assign req_ready = (rst_n && load_ok) ? grant : '0;
  rr_pick4 u_pick (.req(req_eff), .ptr(ptr), .grant(grant), .id(win_id), .any(any));
  Mux4Way16 u_mux (.a(a), .b(b), .c(c), .d(d), .sel(win_id), .out(mux_out));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
      ptr <= 2'd0;
      out_data <= '0;
      out_id <= 2'd0;
    end else if (load_ok) begin
      if (any) begin
        out_data <= mux_out;
        out_id <= win_id;
`ifdef ARB4WAY16_BURST_EN
        state <= req_lock[win_id] ? LOCKED : FULL;
        ptr <= req_lock[win_id] ? ptr : rr_next(win_id);
`else
        state <= FULL;
        ptr <= rr_next(win_id);
`endif
      end else begin
        state <= EMPTY;
`ifdef ARB4WAY16_BURST_EN
        if (state == LOCKED) ptr <= rr_next(out_id);
`endif
      end
    end
  end
endmodule

// File: tb/tb_arbiter4way16.sv
// tb_arbiter4way16: scoreboard bench for arbiter4way16
module tb_arbiter4way16;
  logic clk = 0, rst_n = 0, out_ready = 1, out_valid;
  logic [15:0] a = 0, b = 0, c = 0, d = 0, out_data;
  logic [3:0] req_valid = 0, req_lock = 0, req_ready;
  logic [1:0] out_id;
  int checks = 0, errors = 0;
  int m_ptr = 0, m_state = 0, m_lid = 0;
  logic [17:0] q[$];

  always #5 clk = ~clk;

  arbiter4way16 dut (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
    .req_valid(req_valid), .req_lock(req_lock), .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id), .out_ready(out_ready));

  function automatic logic [15:0] dat(input int i);
    return i == 0 ? a : i == 1 ? b : i == 2 ? c : d;
  endfunction

  task automatic model_init;
    m_ptr = 0; m_state = 0; m_lid = 0; q.delete();
  endtask

  task automatic do_reset;
    rst_n = 0; req_valid = 0; req_lock = 0; out_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    model_init();
  endtask

  task automatic step(input logic [3:0] v, input logic [3:0] l, input logic o);
    logic [3:0] eff, exp_rr;
    int win;
    bit ov, lok;
    req_valid = v; req_lock = l; out_ready = o;
    ov = m_state != 0;
    lok = !ov || o;
    eff = v;
`ifdef ARB4WAY16_BURST_EN
    if (m_state == 2 && v[m_lid]) eff = 4'(1 << m_lid);
`endif
    win = -1;
    for (int k = 0; k < 4; k++) if (win < 0 && eff[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
    exp_rr = (lok && win >= 0) ? 4'(1 << win) : 4'b0000;
    @(negedge clk);
    checks++;
    if (req_ready !== exp_rr) begin errors++; $display("FAIL req_ready got %b exp %b", req_ready, exp_rr); end
    @(posedge clk);
    if (ov && o && q.size() > 0) void'(q.pop_front());
    if (lok) begin
      if (win >= 0) begin
        q.push_back({2'(win), dat(win)});
        m_lid = win;
`ifdef ARB4WAY16_BURST_EN
        if (l[win]) m_state = 2;
        else begin m_state = 1; m_ptr = (win + 1) % 4; end
`else
        m_state = 1; m_ptr = (win + 1) % 4;
`endif
      end else begin
`ifdef ARB4WAY16_BURST_EN
        if (m_state == 2) m_ptr = (m_lid + 1) % 4;
`endif
        m_state = 0;
      end
    end
    #1;
    checks++;
    if (out_valid !== (m_state != 0)) begin errors++; $display("FAIL out_valid got %b exp %b", out_valid, m_state != 0); end
    if (m_state != 0 && q.size() > 0) begin
      checks++;
      if ({out_id, out_data} !== q[0]) begin errors++; $display("FAIL out_word got %0d/%h exp %0d/%h", out_id, out_data, q[0][17:16], q[0][15:0]); end
    end
  endtask

  task automatic test_reset;
    rst_n = 0; req_valid = 4'b1111; out_ready = 1;
    a = 16'h1111; b = 16'h2222; c = 16'h3333; d = 16'h4444;
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_id !== 2'd0) begin
        errors++; $display("FAIL reset_state got v=%b data=%h id=%0d exp 0", out_valid, out_data, out_id);
      end
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    end
    @(posedge clk); #1 rst_n = 1;
    model_init();
    step(4'b1111, 4'b0000, 1'b1);
    checks++;
    if (out_id !== 2'd0 || out_data !== 16'h1111) begin errors++; $display("FAIL reset_first_win got %0d/%h exp 0/1111", out_id, out_data); end
  endtask

  task automatic test_round_robin;
    int ids[5] = '{0, 1, 2, 3, 0};
    logic [15:0] ds[5] = '{16'h000A, 16'h000B, 16'h000C, 16'h000D, 16'h000A};
    do_reset();
    a = 16'h000A; b = 16'h000B; c = 16'h000C; d = 16'h000D;
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 4'b0000, 1'b1);
      checks++;
      if (out_id !== 2'(ids[i]) || out_data !== ds[i]) begin
        errors++; $display("FAIL rr_seq%0d got %0d/%h exp %0d/%h", i, out_id, out_data, ids[i], ds[i]);
      end
    end
  endtask

  task automatic test_back_pressure;
    do_reset();
    a = 16'h0001; b = 16'h0002; c = 16'h1234; d = 16'h0004;
    step(4'b0100, 4'b0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, 4'b0000, 1'b0);
      checks++;
      if (out_data !== 16'h1234 || req_ready !== 4'b0000) begin
        errors++; $display("FAIL stall%0d got %h/%b exp 1234/0000", i, out_data, req_ready);
      end
    end
    step(4'b1111, 4'b0000, 1'b1);
    checks++;
    if (out_id !== 2'd3 || out_data !== 16'h0004) begin errors++; $display("FAIL stall_release got %0d/%h exp 3/0004", out_id, out_data); end
  endtask

  task automatic test_sparse_drain;
    do_reset();
    c = 16'hBEEF;
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b0100, 4'b0000, 1'b1);
    checks++;
    if (out_data !== 16'hBEEF || dut.ptr !== 2'd3) begin errors++; $display("FAIL sparse got %h ptr %0d exp BEEF ptr 3", out_data, dut.ptr); end
    step(4'b0000, 4'b0000, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'hBEEF) begin errors++; $display("FAIL drain got v=%b %h exp v=0 BEEF", out_valid, out_data); end
  endtask

  task automatic test_burst;
    logic [3:0] locks[4] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000};
`ifdef ARB4WAY16_BURST_EN
    int ids[4] = '{1, 1, 1, 2};
`else
    int ids[4] = '{1, 2, 3, 0};
`endif
    do_reset();
    a = 16'h00A0; b = 16'h00B1; c = 16'h00C2; d = 16'h00D3;
    step(4'b0001, 4'b0000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(4'b1111, locks[i], 1'b1);
      checks++;
      if (out_id !== 2'(ids[i])) begin errors++; $display("FAIL burst%0d got %0d exp %0d", i, out_id, ids[i]); end
    end
  endtask

  task automatic test_random;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
      step(4'($urandom), 4'($urandom), 1'($urandom_range(0, 3) != 0));
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_back_pressure();
    test_sparse_drain();
    test_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
